// File: rtl/fetch_queue_pkg.sv
// Shared pipeline definitions for the fetch queue and the decode stage.
package fetch_queue_pkg;

  localparam int ENTRY_WIDTH = 32;

  // Decode also uses this word as its flush value, so an empty queue looks like a bubble
  localparam logic [31:0] NOP_INSTRUCTION = 32'h00000013;

  typedef struct packed {
    logic [ENTRY_WIDTH-1:0] pc;
    logic [ENTRY_WIDTH-1:0] instruction;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction fetch queue between the instruction engine and decode.
// Fetch can run ahead of decode through stalls. A redirect flush drains the queue in one cycle.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int REG_WIDTH = ENTRY_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_push_valid,
  input  logic [REG_WIDTH-1:0]     i_push_pc,
  input  logic [REG_WIDTH-1:0]     i_push_instruction,
  output logic                     o_push_ready,
  output logic                     o_pop_valid,
  output logic [REG_WIDTH-1:0]     o_pop_pc,
  output logic [REG_WIDTH-1:0]     o_pop_instruction,
  input  logic                     i_pop,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t   storage [DEPTH];
  logic [PW-1:0]  wptr;
  logic [PW-1:0]  rptr;
  logic [CW-1:0]  count;
  logic           overflow;
  logic           full;
  logic           empty;
  logic           pop_fire;
  logic           push_fire;
  fetch_entry_t   head;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A full queue still takes a push when the head leaves in the same cycle; flush wins over both
  assign pop_fire  = i_pop && !empty && !i_flush;
  assign push_fire = i_push_valid && (!full || pop_fire) && !i_flush;

  assign o_push_ready = !full;
  assign o_pop_valid  = !empty;
  assign o_count      = count;
  assign o_overflow   = overflow;

  // Head is read straight from storage, so a new entry shows up only after it is registered
  always_comb begin
    head              = storage[rptr];
    o_pop_pc          = '0;
    o_pop_instruction = REG_WIDTH'(NOP_INSTRUCTION);
    if (!empty) begin
      o_pop_pc          = head.pc;
      o_pop_instruction = head.instruction;
    end
  end

  // Entry storage has no reset because count and the pointers decide what is valid
  always_ff @(posedge clk) begin
    if (push_fire) begin
      storage[wptr].pc          <= i_push_pc;
      storage[wptr].instruction <= i_push_instruction;
    end
  end

  // Pointer and occupancy bookkeeping, with the pointers wrapping naturally modulo DEPTH
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_fire) wptr <= wptr + PW'(1);
      if (pop_fire)  rptr <= rptr + PW'(1);
      case ({push_fire, pop_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag survives a flush so the error stays visible until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (i_push_valid && full && !pop_fire && !i_flush) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue using a scoreboard queue of expected entries.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int RW    = 32;

  logic            clk;
  logic            rst;
  logic            i_flush;
  logic            i_push_valid;
  logic [RW-1:0]   i_push_pc;
  logic [RW-1:0]   i_push_instruction;
  logic            o_push_ready;
  logic            o_pop_valid;
  logic [RW-1:0]   o_pop_pc;
  logic [RW-1:0]   o_pop_instruction;
  logic            i_pop;
  logic [2:0]      o_count;
  logic            o_overflow;

  fetch_entry_t    sb [$];
  logic            expOverflow;
  int              compared;
  int              mismatched;
  logic [RW-1:0]   nextPc;

  fetch_queue #(.DEPTH(DEPTH), .REG_WIDTH(RW)) dut (
    .clk                (clk),
    .rst                (rst),
    .i_flush            (i_flush),
    .i_push_valid       (i_push_valid),
    .i_push_pc          (i_push_pc),
    .i_push_instruction (i_push_instruction),
    .o_push_ready       (o_push_ready),
    .o_pop_valid        (o_pop_valid),
    .o_pop_pc           (o_pop_pc),
    .o_pop_instruction  (o_pop_instruction),
    .i_pop              (i_pop),
    .o_count            (o_count),
    .o_overflow         (o_overflow)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Compare all outputs against the scoreboard state before the next edge
  task automatic checkState();
    checkOutput("count", 64'(o_count), 64'(sb.size()));
    checkOutput("pop_valid", 64'(o_pop_valid), 64'(sb.size() != 0));
    checkOutput("push_ready", 64'(o_push_ready), 64'(sb.size() != DEPTH));
    checkOutput("overflow", 64'(o_overflow), 64'(expOverflow));
    if (sb.size() != 0) begin
      checkOutput("head_pc", 64'(o_pop_pc), 64'(sb[0].pc));
      checkOutput("head_instr", 64'(o_pop_instruction), 64'(sb[0].instruction));
    end else begin
      checkOutput("empty_pc", 64'(o_pop_pc), 64'd0);
      checkOutput("empty_instr", 64'(o_pop_instruction), 64'h13);
    end
  endtask

  // Drive one cycle of stimulus, advance the scoreboard, and step past the edge
  task automatic applyStimulus(input logic push, input logic [RW-1:0] pc, input logic [RW-1:0] instr,
                               input logic pop, input logic flush);
    logic popFire;
    logic pushFire;
    fetch_entry_t e;
    checkState();
    i_push_valid       = push;
    i_push_pc          = pc;
    i_push_instruction = instr;
    i_pop              = pop;
    i_flush            = flush;
    popFire  = pop && (sb.size() != 0) && !flush;
    pushFire = push && ((sb.size() != DEPTH) || popFire) && !flush;
    if (push && (sb.size() == DEPTH) && !popFire && !flush) expOverflow = 1'b1;
    if (flush) begin
      sb.delete();
    end else begin
      if (popFire) void'(sb.pop_front());
      if (pushFire) begin
        e.pc = pc;
        e.instruction = instr;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    i_push_valid = 1'b0;
    i_pop        = 1'b0;
    i_flush      = 1'b0;
  endtask

  // Synchronous reset for one edge, clearing the model too
  task automatic doReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    expOverflow = 1'b0;
  endtask

  task automatic fillFour(input logic [RW-1:0] basePc);
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b1, basePc + RW'(4 * i), RW'(32'hA0 + i), 1'b0, 1'b0);
  endtask

  // Directed scenarios followed by a random interleaving that wraps the pointers
  initial begin
    compared = 0;
    mismatched = 0;
    expOverflow = 1'b0;
    rst = 1'b1;
    i_flush = 1'b0;
    i_push_valid = 1'b0;
    i_push_pc = '0;
    i_push_instruction = '0;
    i_pop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    doReset();

    // Reset then idle
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);

    // Fill and drain
    fillFour(32'h0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);

    // Full with simultaneous push and pop
    fillFour(32'h0);
    applyStimulus(1'b1, 32'h10, 32'hB0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);

    // Overflow, held through a flush
    fillFour(32'h100);
    applyStimulus(1'b1, 32'h200, 32'hBAD, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);

    // Flush with push and pop at two entries; the pushed entry must vanish
    applyStimulus(1'b1, 32'h300, 32'hC0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h304, 32'hC1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h308, 32'hC2, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h400, 32'hD0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);

    // Only reset clears overflow
    doReset();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);

    // Random interleaving across several pointer wraps
    nextPc = 32'h1000;
    for (int i = 0; i < 40; i++) begin
      logic doPush;
      logic doPop;
      doPush = ($urandom_range(0, 9) < 7);
      doPop  = ($urandom_range(0, 9) < 6);
      applyStimulus(doPush, nextPc, RW'($urandom), doPop, 1'b0);
      nextPc = nextPc + 32'h4;
    end
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
